// File: rtl/lfsr_gen.sv
// Galois LFSR word generator with a valid/ready output port.
// A load captures a seed (zero seeds are replaced by SEED and flagged),
// after which every accepted word advances the register by STEP shifts.
module lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'h8005,
    parameter int               STEP  = 1,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             load_in,
    input  logic             en_in,
    input  logic             ready_in,
    output logic [WIDTH-1:0] q_out,
    output logic             valid_out,
    output logic             lockup_out,
    output logic [31:0]      cnt_out,
    output logic             dbg_state_out
);

    // Parameter legality is enforced at elaboration.
    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be within 4..64");
    end
    if (TAPS[0] == 1'b0) begin : g_bad_taps
        $error("lfsr_gen: TAPS[0] must be 1");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
        $error("lfsr_gen: STEP must be within 1..WIDTH");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Handshake: a word is transferred on a rising edge where valid_out,
    // ready_in and en_in are all high. valid_out depends only on the FSM
    // state and q_out comes straight from the register, so neither has a
    // combinational path from ready_in.

    logic [WIDTH-1:0] r_q;
    logic [0:0]       r_state;
    logic             r_lockup;
    logic [31:0]      r_cnt;
    logic [1:0]       r_rst_sync;

    logic [WIDTH-1:0] w_adv;
    logic             w_ready_to_run;
    logic             w_accept;
    logic             w_load;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;

    // One Galois shift: shift left, fold the feedback mask in when the
    // outgoing msb was set.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] r);
        shift_once = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? TAPS : '0);
    endfunction

    // Reset synchroniser: asserts immediately, releases after two edges.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_ready_to_run = r_rst_sync[1];

    // STEP chained shifts evaluated within one cycle.
    always_comb begin
        w_adv = r_q;
        for (int i = 0; i < STEP; i++) begin
            w_adv = shift_once(w_adv);
        end
    end

    assign w_seed_zero = (seed_in == '0);
    assign w_load_val  = w_seed_zero ? SEED : seed_in;
    assign w_load      = load_in && w_ready_to_run;
    assign w_accept    = (r_state == ST_RUN) && ready_in && en_in && w_ready_to_run;

    // Main state: load has priority over an acceptance in the same cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_q      <= SEED;
            r_state  <= ST_IDLE;
            r_lockup <= 1'b0;
            r_cnt    <= 32'd0;
        end else if (w_load) begin
            r_q      <= w_load_val;
            r_state  <= ST_RUN;
            r_lockup <= w_seed_zero;
            r_cnt    <= 32'd0;
        end else if (w_accept) begin
            r_q      <= w_adv;
            r_cnt    <= r_cnt + 32'd1;
        end
    end

    assign q_out         = r_q;
    assign valid_out     = (r_state == ST_RUN);
    assign lockup_out    = r_lockup;
    assign cnt_out       = r_cnt;
    assign dbg_state_out = r_state[0];

endmodule
